ecc_secded_codec: RTL and testbench
===================================

Name: ecc_secded_codec

Overview:
- Parametrised, pipelined SEC-DED (Hsiao) codec that replaces the fixed combinational 32-bit encoder.
- Each transaction selects encode or decode mode independently.
- Decode mode corrects single-bit errors and flags double or uncorrectable errors.
- Sits between the datapath and the NVM/SRAM interface, uses valid/ready handshakes on both sides, and keeps saturating error statistics for the register bank.

Parameters:
- DATA_W, 32, payload width; legal values 8, 16, 32, 64.
- PAR_W, derived from DATA_W (8→5, 16→6, 32→7, 64→8), check-bit width; not overridable.
- PAR_INV, {PAR_W{1'b0}}, XOR mask applied to stored check bits, so all-zero data does not give all-zero parity.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- in_vld  in  1  input transaction valid.
- in_rdy  out  1  input accepted when in_vld&in_rdy.
- in_mode  in  1  0=encode, 1=decode.
- in_data  in  DATA_W  payload; raw data when encoding, stored data when decoding.
- in_par  in  PAR_W  stored check bits (decode only; ignored in encode).
- out_vld  out  1  result valid.
- out_rdy  in  1  downstream accepts when out_vld&out_rdy.
- out_data  out  DATA_W  payload; corrected in decode mode.
- out_par  out  PAR_W  encode: computed check bits XOR PAR_INV; decode: raw syndrome.
- out_sec  out  1  decode: single error corrected (data or check bit).
- out_ded  out  1  decode: uncorrectable error; out_data passed through uncorrected.
- cnt_clr  in  1  synchronous clear of both counters.
- sec_cnt  out  CNT_W  saturating count of sec results delivered.
- ded_cnt  out  CNT_W  saturating count of ded results delivered.

Behaviour:
- H-matrix columns:
  - Check bit k uses the unit vector 1<<k.
  - Data bit j uses the j-th entry of an ordered list: all weight-3 PAR_W-bit vectors ascending by value, followed by weight-5 vectors ascending by value.
- Encode: par = XOR of the columns of all set data bits; out_par = par ^ PAR_INV.
- Decode: syndrome = H·data ^ (in_par ^ PAR_INV). Classification:
  - Zero: clean, no flags.
  - Matches data column j: flip data bit j, out_sec=1.
  - Matches a unit vector: check-bit error, data unchanged, out_sec=1.
  - Nonzero even weight, or odd weight with no matching column: out_ded=1.
- Encode results always have out_sec=out_ded=0.
- Pipeline has two stages:
  - S1 registers data, mode and syndrome/parity.
  - S2 registers corrected data and flags.
  - Latency is 2 cycles from accept to out_vld when not stalled; throughput is 1 per cycle.
- Stall logic:
  - s2_en = ~out_vld | out_rdy
  - s1_en = ~s1_vld | s2_en
  - in_rdy = s1_en
  - Registers do not change while stalled; out_* holds stable while out_vld&~out_rdy.
- Counters:
  - Increment only on an output handshake of a decode result carrying sec (or ded), and saturate at all-ones.
  - If cnt_clr coincides with an increment, clear wins and the result is 0.
- Reset:
  - Asserting rst_n low at any time, including mid-transaction, clears all stage valids. In-flight data is dropped and nothing is emitted.
  - Reset values: out_vld=0, out_data=0, out_par=0, out_sec=0, out_ded=0, sec_cnt=0, ded_cnt=0.
  - in_rdy=1 immediately after reset.
- X on in_data/in_par while in_vld=0 has no effect.

Decomposition:
- Package ecc_secded_pkg holds:
  - the PAR_W lookup function of DATA_W;
  - the column-generation function (returns the H column for data bit j);
  - the constants ECC_MODE_ENC=1'b0 and ECC_MODE_DEC=1'b1.
- One sub-module, ecc_secded_syn, is combinational: data plus optional parity in, syndrome/parity out. The top instantiates it once in S1.
- Correction, pipeline and counters live in the top module.

Test Plan (DATA_W=32, PAR_W=7, PAR_INV=0 unless noted):
- Encode 32'h0000_0001 → out_par=7'h07 after 2 cycles; encode 32'h0000_0003 → out_par=7'h0C; encode 0 with PAR_INV=7'h55 → out_par=7'h55.
- Decode data=32'h0000_0001, par=7'h07 → data unchanged, flags 0. Decode data=32'h0000_0003, par=7'h07 → out_data=32'h1, out_sec=1, sec_cnt=1. Decode data=32'h1, par=7'h06 → out_data=32'h1, out_sec=1.
- Decode data=32'h0000_0003, par=7'h00 (syndrome 7'h0C, even weight) → out_ded=1, out_data=32'h3, ded_cnt=1.
- Back-to-back 8 transactions with out_rdy held low for cycles 3–6:
  - in_rdy drops once both stages are full;
  - output order and values are preserved;
  - no duplication or loss;
  - out_* stable while stalled.
- Preload sec_cnt to 16'hFFFF via 65535 sec results, then one more → stays 16'hFFFF. Assert cnt_clr on the same cycle as a sec handshake → sec_cnt=0.
- Pull rst_n low with 2 transactions in flight → out_vld=0 asynchronously, counters 0. After release, the first new transaction emerges 2 cycles after accept.

Source files
------------

// File: rtl/ecc_secded_pkg.sv
// ----------------------------------------------------------------------------
// ecc_secded_pkg
// Shared definitions for the Hsiao SEC-DED codec.
//   ecc_par_w(data_w)   : check-bit width for a legal payload width
//                         (8->5, 16->6, 32->7, 64->8, anything else -> 0).
//   ecc_h_col(par_w, j) : H-matrix column of data bit j. The column list is
//                         every weight-3 par_w-bit vector in ascending order,
//                         followed by every weight-5 vector in ascending order.
//   ECC_MODE_ENC/DEC    : transaction mode encodings on in_mode.
// ----------------------------------------------------------------------------
package ecc_secded_pkg;

    localparam logic ECC_MODE_ENC = 1'b0;
    localparam logic ECC_MODE_DEC = 1'b1;

    // Widest check-bit vector of any legal configuration (DATA_W = 64).
    localparam int unsigned ECC_MAX_PAR_W = 8;

    function automatic int unsigned ecc_par_w(input int unsigned data_w);
        int unsigned pw;
        case (data_w)
            8:       pw = 5;
            16:      pw = 6;
            32:      pw = 7;
            64:      pw = 8;
            default: pw = 0;
        endcase
        return pw;
    endfunction

    // Only ever evaluated with constant arguments, so the loops fold away at
    // elaboration time and each column becomes a constant.
    function automatic logic [ECC_MAX_PAR_W-1:0] ecc_h_col(input int unsigned par_w,
                                                           input int unsigned j);
        int unsigned idx;
        logic [ECC_MAX_PAR_W-1:0] col;
        idx = 0;
        col = '0;
        for (int unsigned w = 3; w <= 5; w += 2) begin
            for (int unsigned v = 1; v < (32'd1 << par_w); v++) begin
                if ($countones(v) == w) begin
                    if (idx == j) begin
                        col = v[ECC_MAX_PAR_W-1:0];
                    end
                    idx++;
                end
            end
        end
        return col;
    endfunction

endpackage

// File: rtl/ecc_secded_syn.sv
// ----------------------------------------------------------------------------
// ecc_secded_syn
// Combinational H-matrix product: syn = H * data ^ par.
// With par = 0 the result is the raw check bits of data (encode); with par set
// to the stored, unmasked check bits the result is the syndrome (decode).
//   data : payload, DATA_W bits
//   par  : check bits folded into the result, PAR_W bits
//   syn  : parity / syndrome, PAR_W bits
// ----------------------------------------------------------------------------
module ecc_secded_syn
    import ecc_secded_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned PAR_W  = ecc_par_w(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [PAR_W-1:0]  par,
    output logic [PAR_W-1:0]  syn
);

    logic [PAR_W-1:0] cols [DATA_W];

    for (genvar j = 0; j < DATA_W; j++) begin : g_col
        localparam logic [ECC_MAX_PAR_W-1:0] COL = ecc_h_col(PAR_W, j);
        assign cols[j] = COL[PAR_W-1:0];
    end

    always_comb begin
        syn = par;
        for (int j = 0; j < int'(DATA_W); j++) begin
            if (data[j]) begin
                syn = syn ^ cols[j];
            end
        end
    end

endmodule

// File: rtl/ecc_secded_codec.sv
// ----------------------------------------------------------------------------
// ecc_secded_codec
// Two-stage pipelined Hsiao SEC-DED encoder/decoder with saturating error
// statistics.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_vld/in_rdy       : input handshake
//   in_mode             : ECC_MODE_ENC (0) or ECC_MODE_DEC (1)
//   in_data/in_par      : payload and stored check bits (check bits decode only)
//   out_vld/out_rdy     : output handshake
//   out_data            : payload, corrected when decoding
//   out_par             : encode -> check bits ^ PAR_INV, decode -> syndrome
//   out_sec/out_ded     : decode single-error-corrected / uncorrectable flags
//   cnt_clr             : synchronous clear of both counters
//   sec_cnt/ded_cnt     : saturating counts of delivered sec / ded results
//
// Handshake: a transfer happens on a rising edge where valid && ready. A
// producer holding valid keeps its payload stable until the transfer; valid
// never depends on ready. in_rdy only reflects pipeline space and is
// independent of in_vld. While out_vld && !out_rdy every out_* is frozen.
//
// Pipeline: S1 holds data, mode and syndrome (decode) or masked parity
// (encode); S2 holds the corrected payload and flags and drives out_*.
// ----------------------------------------------------------------------------
module ecc_secded_codec
    import ecc_secded_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned PAR_W  = ecc_par_w(DATA_W),
    parameter  logic [PAR_W-1:0] PAR_INV = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PAR_W-1:0]  in_par,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_par,
    output logic              out_sec,
    output logic              out_ded,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    // ------------------------------------------------------------------
    // Stage enables
    // ------------------------------------------------------------------
    logic s1_vld_q, s1_vld_d;
    logic out_vld_q, out_vld_d;
    logic s1_en, s2_en, in_acc, out_hs;

    assign s2_en  = ~out_vld_q | out_rdy;
    assign s1_en  = ~s1_vld_q | s2_en;
    assign in_acc = in_vld & s1_en;
    assign out_hs = out_vld_q & out_rdy;

    // ------------------------------------------------------------------
    // S1: H-matrix product of the incoming word
    // ------------------------------------------------------------------
    logic [PAR_W-1:0] syn_par_in;
    logic [PAR_W-1:0] syn_out;

    // Stored check bits are unmasked before entering the product so a clean
    // codeword yields a zero syndrome regardless of PAR_INV.
    assign syn_par_in = (in_mode == ECC_MODE_DEC) ? (in_par ^ PAR_INV) : '0;

    ecc_secded_syn #(
        .DATA_W (DATA_W)
    ) u_syn (
        .data (in_data),
        .par  (syn_par_in),
        .syn  (syn_out)
    );

    logic              s1_mode_q, s1_mode_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [PAR_W-1:0]  s1_syn_q,  s1_syn_d;

    // ------------------------------------------------------------------
    // S2: correction from the registered syndrome
    // ------------------------------------------------------------------
    logic [PAR_W-1:0] cols [DATA_W];

    for (genvar j = 0; j < DATA_W; j++) begin : g_col
        localparam logic [ECC_MAX_PAR_W-1:0] COL = ecc_h_col(PAR_W, j);
        assign cols[j] = COL[PAR_W-1:0];
    end

    logic [DATA_W-1:0] corr_data;
    logic              corr_sec;
    logic              corr_ded;
    logic              col_hit;

    // A nonzero syndrome is correctable only if it equals a data column
    // (flip that bit) or a unit vector (check-bit error, data untouched).
    // Every other nonzero value, even or odd weight, is uncorrectable.
    always_comb begin
        corr_data = s1_data_q;
        corr_sec  = 1'b0;
        corr_ded  = 1'b0;
        col_hit   = 1'b0;
        if ((s1_mode_q == ECC_MODE_DEC) && (s1_syn_q != '0)) begin
            for (int j = 0; j < int'(DATA_W); j++) begin
                if (s1_syn_q == cols[j]) begin
                    corr_data[j] = ~s1_data_q[j];
                    col_hit      = 1'b1;
                end
            end
            if (col_hit || $onehot(s1_syn_q)) begin
                corr_sec = 1'b1;
            end else begin
                corr_ded = 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [PAR_W-1:0]  out_par_q,  out_par_d;
    logic              out_sec_q,  out_sec_d;
    logic              out_ded_q,  out_ded_d;
    logic [CNT_W-1:0]  sec_cnt_q,  sec_cnt_d;
    logic [CNT_W-1:0]  ded_cnt_q,  ded_cnt_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        s1_syn_d   = s1_syn_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_par_d  = out_par_q;
        out_sec_d  = out_sec_q;
        out_ded_d  = out_ded_q;
        sec_cnt_d  = sec_cnt_q;
        ded_cnt_d  = ded_cnt_q;

        if (s1_en) begin
            s1_vld_d = in_vld;
        end
        // Payload registers load only on an accepted word, so whatever sits
        // on in_data/in_par while in_vld is low never enters the pipeline.
        if (in_acc) begin
            s1_mode_d = in_mode;
            s1_data_d = in_data;
            s1_syn_d  = (in_mode == ECC_MODE_DEC) ? syn_out : (syn_out ^ PAR_INV);
        end

        if (s2_en) begin
            out_vld_d = s1_vld_q;
        end
        if (s2_en && s1_vld_q) begin
            out_data_d = corr_data;
            out_par_d  = s1_syn_q;
            out_sec_d  = corr_sec;
            out_ded_d  = corr_ded;
        end

        // Flags are only ever set on decode results, so counting the held
        // flags on a handshake counts delivered decode errors only.
        if (cnt_clr) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (out_hs) begin
            if (out_sec_q && !(&sec_cnt_q)) begin
                sec_cnt_d = sec_cnt_q + 1'b1;
            end
            if (out_ded_q && !(&ded_cnt_q)) begin
                ded_cnt_d = ded_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_mode_q  <= ECC_MODE_ENC;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_par_q  <= '0;
            out_sec_q  <= 1'b0;
            out_ded_q  <= 1'b0;
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_mode_q  <= s1_mode_d;
            s1_data_q  <= s1_data_d;
            s1_syn_q   <= s1_syn_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_par_q  <= out_par_d;
            out_sec_q  <= out_sec_d;
            out_ded_q  <= out_ded_d;
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
        end
    end

    assign in_rdy   = s1_en;
    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_par  = out_par_q;
    assign out_sec  = out_sec_q;
    assign out_ded  = out_ded_q;
    assign sec_cnt  = sec_cnt_q;
    assign ded_cnt  = ded_cnt_q;

endmodule

// File: tb/tb_ecc_secded_codec.sv
// ----------------------------------------------------------------------------
// tb_ecc_secded_codec
// Bench for ecc_secded_codec (DATA_W=32, PAR_W=7). A main instance with
// PAR_INV=0 is driven through directed and random traffic; a second instance
// with PAR_INV=7'h55 covers the parity mask.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ecc_secded_codec;
  import ecc_secded_pkg::*;

  localparam int DW    = 32;
  localparam int PW    = 7;
  localparam int CW    = 16;
  localparam int EXP_W = DW + PW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- main DUT ----------------
  logic          in_vld, in_rdy, in_mode;
  logic [DW-1:0] in_data;
  logic [PW-1:0] in_par;
  logic          out_vld, out_rdy;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_par;
  logic          out_sec, out_ded, cnt_clr;
  logic [CW-1:0] sec_cnt, ded_cnt;

  ecc_secded_codec #(.DATA_W(DW), .CNT_W(CW), .PAR_INV(7'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_mode(in_mode),
    .in_data(in_data), .in_par(in_par),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_par(out_par),
    .out_sec(out_sec), .out_ded(out_ded),
    .cnt_clr(cnt_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  // ---------------- masked-parity DUT ----------------
  logic          iv_vld, iv_rdy, iv_mode;
  logic [DW-1:0] iv_data;
  logic [PW-1:0] iv_par;
  logic          iv_out_vld, iv_out_rdy;
  logic [DW-1:0] iv_out_data;
  logic [PW-1:0] iv_out_par;
  logic          iv_out_sec, iv_out_ded, iv_cnt_clr;
  logic [CW-1:0] iv_sec_cnt, iv_ded_cnt;

  ecc_secded_codec #(.DATA_W(DW), .CNT_W(CW), .PAR_INV(7'h55)) dut_inv (
    .clk(clk), .rst_n(rst_n),
    .in_vld(iv_vld), .in_rdy(iv_rdy), .in_mode(iv_mode),
    .in_data(iv_data), .in_par(iv_par),
    .out_vld(iv_out_vld), .out_rdy(iv_out_rdy),
    .out_data(iv_out_data), .out_par(iv_out_par),
    .out_sec(iv_out_sec), .out_ded(iv_out_ded),
    .cnt_clr(iv_cnt_clr), .sec_cnt(iv_sec_cnt), .ded_cnt(iv_ded_cnt)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [PW-1:0]    cols[DW];
  bit saw_block = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Column list straight from the code definition: weight-3 vectors
  // ascending, then weight-5 vectors ascending.
  task automatic build_cols();
    int idx = 0;
    for (int w = 3; w <= 5; w += 2)
      for (int v = 1; v < (1 << PW); v++)
        if ($countones(v) == w && idx < DW) begin
          cols[idx] = v[PW-1:0];
          idx++;
        end
  endtask

  function automatic logic [PW-1:0] ref_enc(input logic [DW-1:0] d);
    logic [PW-1:0] p = '0;
    for (int j = 0; j < DW; j++)
      if (d[j]) p ^= cols[j];
    return p;
  endfunction

  // Decode by nearest codeword: a stored word is correctable when exactly one
  // single-bit flip anywhere in {check bits, data} turns it into a consistent
  // codeword.
  function automatic logic [EXP_W-1:0] ref_model(input logic mode, input logic [DW-1:0] d,
                                                 input logic [PW-1:0] p, input logic [PW-1:0] pinv);
    logic [DW-1:0]    rd;
    logic [PW-1:0]    rp;
    logic [DW+PW-1:0] cw, fl;
    logic             sec, ded;
    int               hits;
    rp = ref_enc(d) ^ pinv;
    if (mode == ECC_MODE_ENC) return {d, rp, 2'b00};
    rp   = rp ^ p;
    rd   = d;
    sec  = 1'b0;
    ded  = 1'b0;
    hits = 0;
    if (rp != '0) begin
      cw = {p, d};
      for (int i = 0; i < DW + PW; i++) begin
        fl = cw;
        fl[i] = ~fl[i];
        if ((ref_enc(fl[DW-1:0]) ^ pinv) == fl[DW+PW-1:DW]) begin
          hits++;
          rd = fl[DW-1:0];
        end
      end
      if (hits == 1) sec = 1'b1;
      else begin
        ded = 1'b1;
        rd  = d;
      end
    end
    return {rd, rp, sec, ded};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  // with in_vld still high so calls can be chained back to back.
  task automatic send(input logic mode, input logic [DW-1:0] d, input logic [PW-1:0] p,
                      input logic [EXP_W-1:0] e);
    int t = 0;
    in_vld  = 1'b1;
    in_mode = mode;
    in_data = d;
    in_par  = p;
    forever begin
      @(negedge clk);
      if (in_rdy) begin
        exp_q.push_back(e);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL send_timeout: in_rdy stuck low for %0d cycles", t);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_vld  = 1'b0;
    in_mode = 1'($urandom_range(0, 1));
    in_data = $urandom;
    in_par  = 7'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_empty();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
    check("drain", 64'(exp_q.size()), 0);
  endtask

  task automatic send_random(input int kind);
    logic [DW-1:0]    d;
    logic [PW-1:0]    p;
    logic [DW+PW-1:0] cw;
    int a, b;
    d = $urandom;
    if (kind == 0) begin
      send(ECC_MODE_ENC, d, 7'($urandom), ref_model(ECC_MODE_ENC, d, '0, 7'h00));
      return;
    end
    cw = {ref_enc(d), d};
    a  = $urandom_range(0, DW + PW - 1);
    b  = (a + $urandom_range(1, DW + PW - 1)) % (DW + PW);
    case (kind)
      2: cw[a] = ~cw[a];
      3: begin cw[a] = ~cw[a]; cw[b] = ~cw[b]; end
      4: cw[DW+PW-1:DW] = 7'($urandom);
      default: ;
    endcase
    p = cw[DW+PW-1:DW];
    d = cw[DW-1:0];
    send(ECC_MODE_DEC, d, p, ref_model(ECC_MODE_DEC, d, p, 7'h00));
  endtask

  task automatic inv_txn(input logic mode, input logic [DW-1:0] d, input logic [PW-1:0] p);
    logic [EXP_W-1:0] e;
    e = ref_model(mode, d, p, 7'h55);
    iv_vld = 1'b1; iv_mode = mode; iv_data = d; iv_par = p;
    @(negedge clk);
    check("inv_in_rdy", iv_rdy, 1);
    @(posedge clk); #1;
    iv_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("inv_out_vld", iv_out_vld, 1);
    check("inv_out", {iv_out_data, iv_out_par, iv_out_sec, iv_out_ded}, e);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int occ = 0;
    logic [CW-1:0] m_sec = '0;
    logic [CW-1:0] m_ded = '0;
    logic [EXP_W-1:0] e;
    bit hs, acc;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        occ = 0; m_sec = '0; m_ded = '0;
        continue;
      end
      check("sec_cnt", sec_cnt, m_sec);
      check("ded_cnt", ded_cnt, m_ded);
      check("in_rdy", in_rdy, !(occ == 2 && !out_rdy));
      if (!in_rdy) saw_block = 1'b1;
      e  = '0;
      hs = out_vld && out_rdy;
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_out: data %0h par %0h with nothing outstanding", out_data, out_par);
          hs = 1'b0;
        end else begin
          check("out", {out_data, out_par, out_sec, out_ded}, exp_q[0]);
          if (hs) e = exp_q.pop_front();
        end
      end
      if (cnt_clr) begin
        m_sec = '0; m_ded = '0;
      end else if (hs) begin
        if (e[1] && m_sec != '1) m_sec++;
        if (e[0] && m_ded != '1) m_ded++;
      end
      acc = in_vld && in_rdy;
      occ = occ + int'(acc) - int'(hs);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [EXP_W-1:0] e;
    build_cols();
    rst_n = 1'b0; in_vld = 1'b0; in_mode = 1'b0; in_data = '0; in_par = '0;
    out_rdy = 1'b1; cnt_clr = 1'b0;
    iv_vld = 1'b0; iv_mode = 1'b0; iv_data = '0; iv_par = '0; iv_out_rdy = 1'b1; iv_cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_par", out_par, 0);
    check("rst_out_sec", out_sec, 0);
    check("rst_out_ded", out_ded, 0);
    check("rst_sec_cnt", sec_cnt, 0);
    check("rst_ded_cnt", ded_cnt, 0);
    check("rst_in_rdy", in_rdy, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: encode of bit 0 appears two cycles after it is presented.
    send(ECC_MODE_ENC, 32'h0000_0001, 7'h00, {32'h0000_0001, 7'h07, 2'b00});
    idle(0);
    @(negedge clk); check("lat_cycle1", out_vld, 0);
    @(negedge clk); check("lat_cycle2", out_vld, 1);
    @(posedge clk); #1;

    // Directed vectors with hand-derived results.
    send(ECC_MODE_ENC, 32'h0000_0003, 7'h00, {32'h0000_0003, 7'h0C, 2'b00});
    send(ECC_MODE_DEC, 32'h0000_0001, 7'h07, {32'h0000_0001, 7'h00, 2'b00});
    send(ECC_MODE_DEC, 32'h0000_0003, 7'h07, {32'h0000_0001, 7'h0B, 2'b10});
    send(ECC_MODE_DEC, 32'h0000_0001, 7'h06, {32'h0000_0001, 7'h01, 2'b10});
    send(ECC_MODE_DEC, 32'h0000_0003, 7'h00, {32'h0000_0003, 7'h0C, 2'b01});
    idle(4);
    check("dir_sec_cnt", sec_cnt, 2);
    check("dir_ded_cnt", ded_cnt, 1);

    // Eight back-to-back words with the sink stalled for four cycles.
    saw_block = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_random(int'($urandom_range(0, 4)));
        idle(0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_rdy = 1'b1;
      end
    join
    wait_empty();
    check("stall_in_rdy_dropped", saw_block, 1);

    // Random traffic with random sink back-pressure.
    begin
      bit done = 1'b0;
      fork
        begin
          for (int i = 0; i < 300; i++) begin
            send_random(int'($urandom_range(0, 4)));
            if ($urandom_range(0, 3) == 0) idle(1);
          end
          idle(0);
          done = 1'b1;
        end
        begin
          while (!done) begin
            out_rdy = ($urandom_range(0, 9) < 6);
            @(posedge clk); #1;
          end
          out_rdy = 1'b1;
        end
      join
    end
    wait_empty();

    // Saturation of sec_cnt.
    cnt_clr = 1'b1; @(posedge clk); #1 cnt_clr = 1'b0;
    e = {32'h0000_0001, 7'h0B, 2'b10};
    for (int i = 0; i < 65535; i++) send(ECC_MODE_DEC, 32'h0000_0003, 7'h07, e);
    idle(0);
    wait_empty();
    check("sec_cnt_full", sec_cnt, 16'hFFFF);
    send(ECC_MODE_DEC, 32'h0000_0003, 7'h07, e);
    idle(0);
    wait_empty();
    check("sec_cnt_sat", sec_cnt, 16'hFFFF);

    // Clear on the same edge as a sec handshake.
    send(ECC_MODE_DEC, 32'h0000_0003, 7'h07, e);
    idle(0);
    begin
      int t = 0;
      while (!out_vld && t < 20) begin @(posedge clk); #1; t++; end
      check("clr_sees_out_vld", out_vld, 1);
    end
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    check("clr_wins", sec_cnt, 0);

    // Asynchronous reset with two words in flight.
    send(ECC_MODE_DEC, 32'h0000_0003, 7'h00, {32'h0000_0003, 7'h0C, 2'b01});
    idle(0);
    wait_empty();
    check("pre_rst_ded_cnt", ded_cnt, 1);
    out_rdy = 1'b0;
    send_random(int'($urandom_range(0, 4)));
    send_random(int'($urandom_range(0, 4)));
    idle(0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_vld", out_vld, 0);
    check("arst_sec_cnt", sec_cnt, 0);
    check("arst_ded_cnt", ded_cnt, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    begin
      logic [DW-1:0] d = $urandom;
      send(ECC_MODE_ENC, d, 7'h00, ref_model(ECC_MODE_ENC, d, '0, 7'h00));
    end
    idle(0);
    @(negedge clk); check("post_rst_lat1", out_vld, 0);
    @(negedge clk); check("post_rst_lat2", out_vld, 1);
    @(posedge clk); #1;
    wait_empty();

    // Masked-parity instance.
    inv_txn(ECC_MODE_ENC, 32'h0, 7'h00);
    check("inv_enc0_par", iv_out_par, 7'h55);
    inv_txn(ECC_MODE_DEC, 32'h0, 7'h55);
    inv_txn(ECC_MODE_DEC, 32'h0, 7'h54);
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] d = $urandom;
      logic [PW-1:0] p = ref_enc(d) ^ 7'h55;
      inv_txn(ECC_MODE_ENC, d, 7'h00);
      d[$urandom_range(0, DW - 1)] ^= 1'b1;
      inv_txn(ECC_MODE_DEC, d, p);
    end

    idle(4);
    check("no_loss", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
